instr_mem_loader: RTL

- Write-side counterpart to the byte-addressed, little-endian instruction ROM.
- Accepts a length-prefixed byte stream, for example from a UART receiver or a testbench driver, and issues sequential byte writes into the instruction memory array.
- Holds the CPU in reset while a program image is loading.
- Releases the CPU when all declared bytes are written, or flags an error.

---
 rtl/instr_mem_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Write-side loader for the byte-addressed, little-endian instruction memory.
// Takes a length-prefixed byte stream and turns the payload into sequential
// byte writes starting at BASE_ADDR. The stream is a 4-byte little-endian
// length LEN followed by LEN payload bytes. The CPU is held in reset while an
// image is loading. It is released when every declared byte has been written,
// or when the declared length does not fit in memory (error).
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle load request (honoured in IDLE, DONE, ERROR only)
//   byte_valid  upstream byte available
//   byte_data   upstream byte
//   byte_ready  loader accepts a byte this cycle (high in HDR and DATA)
//   mem_we      byte write strobe to instruction memory
//   mem_addr    byte write address
//   mem_wdata   byte write data
//   cpu_hold    keep CPU in reset while loading
//   done        load completed successfully (level)
//   error       declared length exceeds capacity (level)
//   byte_count  payload bytes written so far
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
// byte_data is sampled only on that edge. byte_valid while byte_ready is low
// has no effect. byte_ready depends only on the state, never on byte_valid.
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output logic [31:0]              byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    // Bytes available above BASE_ADDR. This is kept at 33 bits so that a full
    // 32-bit LEN can be compared without overflow.
    localparam logic [32:0] CAPACITY =
        (33'd1 << ADDRESS_WIDTH) - 33'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] BASE_A = ADDRESS_WIDTH'(BASE_ADDR);

    state_t                     state_q, state_d;
    logic [1:0]                 hdr_cnt_q, hdr_cnt_d;
    logic [31:0]                len_q, len_d;
    logic [31:0]                byte_count_q, byte_count_d;
    logic                       mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]                 mem_wdata_q, mem_wdata_d;

    logic                       accept;
    logic [31:0]                len_full;

    assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
    assign cpu_hold   = byte_ready;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign byte_count = byte_count_q;

    assign accept = byte_valid && byte_ready;

    // The header shifts in from the top. After four bytes, the first byte
    // received sits in LEN[7:0]. len_full is the value LEN holds once the
    // current byte has been shifted in.
    assign len_full = {byte_data, len_q[31:8]};

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        len_d        = len_q;
        byte_count_d = byte_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_HDR;
                    hdr_cnt_d    = 2'd0;
                    len_d        = 32'd0;
                    byte_count_d = 32'd0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    len_d     = len_full;
                    hdr_cnt_d = 2'(hdr_cnt_q + 2'd1);
                    if (hdr_cnt_q == 2'd3) begin
                        if (len_full == 32'd0) begin
                            state_d = S_DONE;
                        end else if ({1'b0, len_full} > CAPACITY) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Before the increment, byte_count_q is the 0-based index
                    // of this byte. The range check guarantees that
                    // BASE + index never wraps.
                    mem_we_d     = 1'b1;
                    mem_addr_d   = BASE_A + byte_count_q[ADDRESS_WIDTH-1:0];
                    mem_wdata_d  = byte_data;
                    byte_count_d = byte_count_q + 32'd1;
                    if (byte_count_d == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hdr_cnt_q    <= 2'd0;
            len_q        <= 32'd0;
            byte_count_q <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            len_q        <= len_d;
            byte_count_q <= byte_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule
